musa_fetch_unit: RTL and testbench
==================================

// Module: musa_fetch_unit
// PURPOSE
//  Instruction fetch stage that sits directly upstream of the control unit and decode path.
//  Holds the fetch PC and issues word reads to the synchronous instruction memory, which has a
//  1-cycle read latency. Responses are buffered in a small prefetch FIFO, and instructions are
//  handed to decode over a valid/ready handshake.
//  A redirect (branch, jump or return target) flushes the buffered and in-flight instructions
//  and restarts fetch at the new PC.
// PARAMETERS
//  ADDR_W      18  instruction word-address width
//  DATA_W      32  instruction width
//  FIFO_DEPTH  4   prefetch entries; power of 2, >=2; full throughput needs >=3
//  RESET_PC    0   first fetch address after reset
// PORTS
//  clk             in   1       clock; all state updates on the rising edge
//  rst             in   1       synchronous reset, active-high
//  imem_req        out  1       read enable to the instruction memory
//  imem_addr       out  ADDR_W  read word address (the fetch PC)
//  imem_data       in   DATA_W  read data; valid the cycle after imem_req
//  redirect_valid  in   1       one-cycle pulse: flush and restart fetch
//  redirect_pc     in   ADDR_W  new fetch PC; sampled when redirect_valid=1
//  instr_valid     out  1       FIFO head holds a valid instruction
//  instr_data      out  DATA_W  instruction at the FIFO head
//  instr_pc        out  ADDR_W  address of instr_data
//  instr_ready     in   1       decode accepts the head this cycle
// BEHAVIOUR
//  Reset values:
//   - fetch_pc=RESET_PC; FIFO count=0; inflight=0
//   - imem_req=0; instr_valid=0; instr_data=0; instr_pc=0
//  Issue (combinational):
//   - imem_req = !rst && !redirect_valid && (count + inflight < FIFO_DEPTH)
//   - count and inflight are the registered values; a pop in the same cycle does not free space early
//   - On an issue: fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W (3FFFF -> 0)
//   - On an issue: inflight <= 1 and the issued address is tagged for the response
//  Response:
//   - When inflight=1 and no redirect occurs this cycle: push {imem_data, tag} into the FIFO
//   - Otherwise inflight <= imem_req
//   - The FIFO can never overflow, because its space is reserved at issue time
//  Output:
//   - instr_valid = (count != 0); instr_data and instr_pc come straight from the head entry
//   - Pop when instr_valid && instr_ready
//   - Data and PC stay stable while valid=1 and ready=0
//  Latency:
//   - Request in cycle N; entry written at the end of cycle N+1; instr_valid=1 in cycle N+2
//   - With ready held at 1 and no redirect: 1 instruction/cycle sustained once primed
//  Redirect, in priority over everything except rst:
//   - Any pop in that cycle completes, since decode owns that instruction
//   - The FIFO is then emptied and the in-flight response is discarded (not pushed)
//   - fetch_pc <= redirect_pc; imem_req=0 in the redirect cycle
//   - First new request in the next cycle; target instruction is valid 2 cycles later
//  Simultaneous cases:
//   - push and pop in the same cycle: count unchanged
//   - redirect together with a response: response dropped
//   - back-to-back redirects: the last one wins
//  rst asserted mid-operation: all state returns to reset values at the next edge, and the
//  in-flight read is discarded.
//  State machine: none beyond the count and inflight registers. The FIFO uses wrapping
//  rd/wr pointers of log2(FIFO_DEPTH) bits plus a separate count.
// CONFIGURATION
//  MUSA_FETCH_PERF_EN defined:
//   - Adds outputs perf_fetched (32b) and perf_flushes (16b), both saturating
//   - perf_fetched increments on every pop
//   - perf_flushes increments on every redirect that discards >=1 entry or in-flight read
//   - Both clear on rst
//  MUSA_FETCH_PERF_EN undefined: the ports and logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset, RESET_PC=0, ready=1, imem[n]=n+100:
//    - imem_req in the first cycle after rst falls
//    - instr 100 appears 2 cycles later
//    - then 101, 102, ... one per cycle with matching instr_pc
//  2 ready=0 for 10 cycles:
//    - exactly FIFO_DEPTH requests are issued, then imem_req=0
//    - the head holds 100 stably
//    - releasing ready drains 100..103 in order with no gap and no duplicate
//  3 Redirect to 0x200 while count=3 and inflight=1:
//    - no old instruction appears afterwards
//    - imem_addr=0x200 in the next cycle
//    - instr_pc=0x200 two cycles after that
//  4 Redirect to 0x3FFFF:
//    - instr_pc sequence 3FFFF, 00000, 00001 (wrap)
//  5 Pop in the same cycle as a redirect:
//    - that instruction counts as consumed
//    - the FIFO is empty the next cycle
//    - with PERF_EN: perf_fetched +1 and perf_flushes +1
//  6 rst pulsed for 1 cycle during streaming:
//    - instr_valid=0 the next cycle
//    - fetch restarts at RESET_PC; stale imem_data is never delivered

Source files
------------

// File: rtl/musa_fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle imem reads, prefetch FIFO, valid/ready to decode.
// Optional MUSA_FETCH_PERF_EN adds saturating perf_fetched / perf_flushes counters.
module musa_fetch_unit #(
  parameter int              ADDR_W     = 18,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef MUSA_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [15:0]       perf_flushes
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              inflight;
  logic [ADDR_W-1:0] fetch_pc, tag;
  logic              push, pop;

  always_comb begin
    // Space is reserved against registered count+inflight, so a same-cycle pop
    // cannot free a slot early and the FIFO can never overflow.
    imem_req    = !rst && !redirect_valid && ((count + CNT_W'(inflight)) < DEPTH_C);
    imem_addr   = fetch_pc;
    instr_valid = (count != '0);
    pop         = instr_valid && instr_ready;
    push        = inflight && !redirect_valid;
    instr_data  = instr_valid ? fifo_mem[rd_ptr].data : '0;
    instr_pc    = instr_valid ? fifo_mem[rd_ptr].pc   : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        tag      <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; outputs are gated by count,
  // so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr] <= '{data: imem_data, pc: tag};
  end

`ifdef MUSA_FETCH_PERF_EN
  logic flush_loses_work;
  assign flush_loses_work = inflight || (count > CNT_W'(pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid && flush_loses_work && (perf_flushes != '1))
        perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_musa_fetch_unit.sv
// Directed self-checking bench for musa_fetch_unit with a 1-cycle imem model (imem[n] = n+100).
module tb_musa_fetch_unit;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready = 1'b0;
`ifdef MUSA_FETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [15:0]       perf_flushes;
`endif

  int errors = 0;
  int checks = 0;

  musa_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef MUSA_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, 1-cycle latency.
  always @(posedge clk) begin
    if (imem_req) imem_data <= 32'(imem_addr) + 32'd100;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle with rst low (C0), inputs settled.
  task automatic reset_release(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = rdy;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++;
    if (instr_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", instr_data); end
    checks++;
    if (instr_pc !== 18'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
  endtask

  task automatic test_stream();
    reset_release(1'b1);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 18'h00000})
      begin errors++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    next_cycle(); #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid: got %b want 0", instr_valid); end
    for (int k = 0; k < 6; k++) begin
      next_cycle(); #1;
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 18'(k), 32'(100 + k)}) begin
        errors++;
        $display("FAIL stream_head k=%0d: got v=%b pc=%h d=%0d want v=1 pc=%h d=%0d",
                 k, instr_valid, instr_pc, instr_data, 18'(k), 100 + k);
      end
    end
  endtask

  task automatic test_stall();
    int reqs;
    reqs = 0;
    reset_release(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i != 0) begin next_cycle(); #1; end
      if (imem_req === 1'b1) reqs++;
      if (i >= 2) begin
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, 18'd0, 32'd100}) begin
          errors++;
          $display("FAIL stall_hold c%0d: got v=%b pc=%h d=%0d want v=1 pc=0 d=100",
                   i, instr_valid, instr_pc, instr_data);
        end
      end
    end
    checks++;
    if (reqs !== 4) begin errors++; $display("FAIL stall_req_count: got %0d want 4", reqs); end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_idle: got %b want 0", imem_req); end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      instr_ready = 1'b1;
      #1;
      if (k == 0) begin
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_no_early_free: got %b want 0", imem_req); end
      end
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 18'(k), 32'(100 + k)}) begin
        errors++;
        $display("FAIL stall_drain k=%0d: got v=%b pc=%h d=%0d want v=1 pc=%h d=%0d",
                 k, instr_valid, instr_pc, instr_data, 18'(k), 100 + k);
      end
    end
  endtask

  task automatic test_redirect();
    reset_release(1'b0);
    for (int i = 0; i < 4; i++) begin next_cycle(); #1; end
    // C4: three entries buffered, one read in flight
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 18'd0, 32'd100})
      begin errors++; $display("FAIL redir_pre_head: got v=%b pc=%h d=%0d want v=1 pc=0 d=100", instr_valid, instr_pc, instr_data); end
    redirect_valid = 1'b1;
    redirect_pc = 18'h00200;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_blocked: got %b want 0", imem_req); end
    next_cycle();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    #1;
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 18'h00200})
      begin errors++; $display("FAIL redir_restart: got v=%b req=%b addr=%h want v=0 req=1 addr=00200", instr_valid, imem_req, imem_addr); end
    next_cycle(); #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_gap: got %b want 0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 18'(32'h200 + k), 32'(32'h200 + 100 + k)}) begin
        errors++;
        $display("FAIL redir_target k=%0d: got v=%b pc=%h d=%h want pc=%h",
                 k, instr_valid, instr_pc, instr_data, 18'(32'h200 + k));
      end
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_pc [3];
    logic [DATA_W-1:0] exp_d  [3];
    exp_pc[0] = 18'h3FFFF; exp_d[0] = 32'h0004_0063;
    exp_pc[1] = 18'h00000; exp_d[1] = 32'd100;
    exp_pc[2] = 18'h00001; exp_d[2] = 32'd101;
    reset_release(1'b1);
    for (int i = 0; i < 3; i++) begin next_cycle(); #1; end
    redirect_valid = 1'b1;
    redirect_pc = 18'h3FFFF;
    #1;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 18'h3FFFF})
      begin errors++; $display("FAIL wrap_req_top: got req=%b addr=%h want req=1 addr=3ffff", imem_req, imem_addr); end
    next_cycle(); #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 18'h00000})
      begin errors++; $display("FAIL wrap_req_zero: got req=%b addr=%h want req=1 addr=00000", imem_req, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, exp_pc[k], exp_d[k]}) begin
        errors++;
        $display("FAIL wrap_seq k=%0d: got v=%b pc=%h d=%h want pc=%h d=%h",
                 k, instr_valid, instr_pc, instr_data, exp_pc[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_pop_redirect();
    reset_release(1'b0);
    for (int i = 0; i < 3; i++) begin next_cycle(); #1; end
    // C3: entries 100,101 buffered, 102 in flight; pop 100 together with redirect
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 18'd0, 32'd100})
      begin errors++; $display("FAIL popredir_head: got v=%b pc=%h d=%0d want v=1 pc=0 d=100", instr_valid, instr_pc, instr_data); end
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 18'h00040;
    #1;
`ifdef MUSA_FETCH_PERF_EN
    checks++;
    if ({perf_fetched, perf_flushes} !== {32'd0, 16'd0})
      begin errors++; $display("FAIL popredir_perf_pre: got fetched=%0d flushes=%0d want 0 0", perf_fetched, perf_flushes); end
`endif
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 18'h00040})
      begin errors++; $display("FAIL popredir_empty: got v=%b req=%b addr=%h want v=0 req=1 addr=00040", instr_valid, imem_req, imem_addr); end
`ifdef MUSA_FETCH_PERF_EN
    checks++;
    if ({perf_fetched, perf_flushes} !== {32'd1, 16'd1})
      begin errors++; $display("FAIL popredir_perf_post: got fetched=%0d flushes=%0d want 1 1", perf_fetched, perf_flushes); end
`endif
    next_cycle(); #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL popredir_gap: got %b want 0", instr_valid); end
    next_cycle(); #1;
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 18'h00040, 32'd164})
      begin errors++; $display("FAIL popredir_target: got v=%b pc=%h d=%0d want v=1 pc=00040 d=164", instr_valid, instr_pc, instr_data); end
  endtask

  task automatic test_reset_mid();
    reset_release(1'b1);
    for (int i = 0; i < 5; i++) begin next_cycle(); #1; end
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 18'd3})
      begin errors++; $display("FAIL rstmid_pre: got v=%b pc=%h want v=1 pc=3", instr_valid, instr_pc); end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req_gated: got %b want 0", imem_req); end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b0, 18'd0, 32'd0})
      begin errors++; $display("FAIL rstmid_cleared: got v=%b pc=%h d=%0d want 0 0 0", instr_valid, instr_pc, instr_data); end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 18'd0})
      begin errors++; $display("FAIL rstmid_restart: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    next_cycle(); #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_stale: got %b want 0", instr_valid); end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); #1;
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 18'(k), 32'(100 + k)}) begin
        errors++;
        $display("FAIL rstmid_stream k=%0d: got v=%b pc=%h d=%0d want v=1 pc=%h d=%0d",
                 k, instr_valid, instr_pc, instr_data, 18'(k), 100 + k);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_pop_redirect();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
